// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
// sensor_conditioner: sync/debounce of street sensors and parade buttons,
// P/R pulses and parade-mode level; SENSOR_STRETCH_EN adds TA/TB hold. Rev 1.0
// ============================================================================
module sensor_conditioner #(
  parameter int DEB_CYCLES     = 4,
  parameter int CNT_W          = 3,
  parameter int STRETCH_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_ta,
  input  logic raw_tb,
  input  logic btn_p,
  input  logic btn_r,
  output logic TA,
  output logic TB,
  output logic P,
  output logic R,
  output logic par_mode
);

  localparam int               NCH       = 4;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEB_CYCLES - 1);

  // Channel order: 0 = ta, 1 = tb, 2 = p, 3 = r
  logic [NCH-1:0]   w_raw;
  logic [NCH-1:0]   sync1_q;
  logic [NCH-1:0]   sync2_q;
  logic [NCH-1:0]   stable_q;
  logic [NCH-1:0]   stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [1:0]       btn_prev_q;
  logic [1:0]       w_btn_rise;
  logic             p_q, p_d;
  logic             r_q, r_d;
  logic             par_q, par_d;

  assign w_raw = {btn_r, btn_p, raw_tb, raw_ta};

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == c_cnt_max) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // End-of-parade wins when both buttons settle on the same edge.
  assign w_btn_rise = stable_q[3:2] & ~btn_prev_q;

  always_comb begin
    r_d   = w_btn_rise[1];
    p_d   = w_btn_rise[0] & ~w_btn_rise[1];
    par_d = par_q;
    if (r_q) begin
      par_d = 1'b0;
    end else if (p_q) begin
      par_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      btn_prev_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      p_q        <= 1'b0;
      r_q        <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      sync1_q    <= w_raw;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      btn_prev_q <= stable_q[3:2];
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      p_q        <= p_d;
      r_q        <= r_d;
      par_q      <= par_d;
    end
  end

  assign P        = p_q;
  assign R        = r_q;
  assign par_mode = par_q;

`ifdef SENSOR_STRETCH_EN
  localparam int                HOLD_W      = $clog2(STRETCH_CYCLES + 1);
  localparam logic [HOLD_W-1:0] c_hold_init = HOLD_W'(STRETCH_CYCLES);

  logic [HOLD_W-1:0] hold_q [2];
  logic [HOLD_W-1:0] hold_d [2];
  logic [1:0]        tatb_q;
  logic [1:0]        tatb_d;

  // Hold is armed on the falling edge of stable and cancelled by a re-rise.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hold_d[i] = hold_q[i];
      if (stable_d[i]) begin
        hold_d[i] = '0;
      end else if (stable_q[i]) begin
        hold_d[i] = c_hold_init;
      end else if (hold_q[i] != '0) begin
        hold_d[i] = hold_q[i] - 1'b1;
      end
      tatb_d[i] = stable_d[i] | (hold_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q[0] <= '0;
      hold_q[1] <= '0;
      tatb_q    <= '0;
    end else begin
      hold_q[0] <= hold_d[0];
      hold_q[1] <= hold_d[1];
      tatb_q    <= tatb_d;
    end
  end

  assign TA = tatb_q[0];
  assign TB = tatb_q[1];
`else
  assign TA = stable_q[0];
  assign TB = stable_q[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// tb_sensor_conditioner: directed + random stimulus against a history-based
// reference model; expected outputs queued and checked by a monitor. Rev 1.0
// ============================================================================
module tb_sensor_conditioner;

  localparam int DEB     = 4;
  localparam int CW      = 3;
  localparam int STRETCH = 8;
  localparam int HLEN    = DEB + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw_ta = 1'b0, raw_tb = 1'b0, btn_p = 1'b0, btn_r = 1'b0;
  logic TA, TB, P, R, par_mode;

  sensor_conditioner #(
    .DEB_CYCLES    (DEB),
    .CNT_W         (CW),
    .STRETCH_CYCLES(STRETCH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .raw_ta  (raw_ta),
    .raw_tb  (raw_tb),
    .btn_p   (btn_p),
    .btn_r   (btn_r),
    .TA      (TA),
    .TB      (TB),
    .P       (P),
    .R       (R),
    .par_mode(par_mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Expected vector: {par_mode, R, P, TB, TA}
  logic [4:0] expq [$];

  // Reference model state: raw sample history per channel plus settled levels.
  logic hist0 [$], hist1 [$], hist2 [$], hist3 [$];
  logic [3:0] m_stable;
  logic [3:0] m_rose;
  logic [1:0] m_fell;
  logic       m_p, m_r, m_par;
  bit   [1:0] m_fvalid;
  int         m_since [2];

  function automatic logic settle(ref logic h [$], input logic cur);
    // Flip only if the synchronised value disagreed on each of the last DEB edges.
    bit all_diff = 1'b1;
    for (int i = 0; i < DEB; i++) begin
      if (h[h.size() - 3 - i] == cur) all_diff = 1'b0;
    end
    return all_diff ? ~cur : cur;
  endfunction

  task automatic model_edge(input logic rst, input logic [3:0] raw, output logic [4:0] e);
    logic [3:0] old;
    logic       np, nr, npar;
    if (rst) begin
      hist0 = {}; hist1 = {}; hist2 = {}; hist3 = {};
      for (int k = 0; k < HLEN; k++) begin
        hist0.push_back(1'b0); hist1.push_back(1'b0);
        hist2.push_back(1'b0); hist3.push_back(1'b0);
      end
      m_stable = '0; m_rose = '0; m_fell = '0;
      m_p = 1'b0; m_r = 1'b0; m_par = 1'b0;
      m_fvalid = '0; m_since[0] = 0; m_since[1] = 0;
    end else begin
      nr   = m_rose[3];
      np   = m_rose[2] & ~m_rose[3];
      npar = m_r ? 1'b0 : (m_p ? 1'b1 : m_par);
      hist0.push_back(raw[0]); hist1.push_back(raw[1]);
      hist2.push_back(raw[2]); hist3.push_back(raw[3]);
      if (hist0.size() > HLEN) begin
        void'(hist0.pop_front()); void'(hist1.pop_front());
        void'(hist2.pop_front()); void'(hist3.pop_front());
      end
      old = m_stable;
      m_stable[0] = settle(hist0, old[0]);
      m_stable[1] = settle(hist1, old[1]);
      m_stable[2] = settle(hist2, old[2]);
      m_stable[3] = settle(hist3, old[3]);
      m_rose = m_stable & ~old;
      m_fell = old[1:0] & ~m_stable[1:0];
      for (int c = 0; c < 2; c++) begin
        if (m_fell[c]) begin
          m_fvalid[c] = 1'b1;
          m_since[c]  = 0;
        end else if (m_fvalid[c] && m_since[c] < STRETCH) begin
          m_since[c]++;
        end
      end
      m_p = np; m_r = nr; m_par = npar;
    end
    e[2] = m_p;
    e[3] = m_r;
    e[4] = m_par;
`ifdef SENSOR_STRETCH_EN
    e[0] = m_stable[0] | (m_fvalid[0] && m_since[0] < STRETCH);
    e[1] = m_stable[1] | (m_fvalid[1] && m_since[1] < STRETCH);
`else
    e[0] = m_stable[0];
    e[1] = m_stable[1];
`endif
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%b required=%b", nm, cyc, act, exp);
  endtask

  // Inputs change just after a rising edge; the expectation covers the next edge.
  task automatic step(input logic rst, input logic [3:0] raw);
    logic [4:0] e;
    reset = rst;
    {btn_r, btn_p, raw_tb, raw_ta} = raw;
    model_edge(rst, raw, e);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    for (int i = 0; i < n; i++) step(1'b0, raw);
  endtask

  initial begin : monitor
    logic [4:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("TA", TA, e[0]);
        chk("TB", TB, e[1]);
        chk("P", P, e[2]);
        chk("R", R, e[3]);
        chk("par_mode", par_mode, e[4]);
      end
    end
  end

  initial begin : stimulus
    logic [3:0] val;
    int         hcnt [4];
    // Reset then idle
    step(1'b1, 4'b0000);
    hold(4'b0000, 5);
    // Clean street-A sensor rise and fall
    hold(4'b0001, 12);
    hold(4'b0000, 12);
    // Street-B bounce, then a clean hold
    for (int i = 0; i < 2; i++) begin
      hold(4'b0010, 2);
      hold(4'b0000, 2);
    end
    hold(4'b0000, 8);
    hold(4'b0010, 10);
    hold(4'b0000, 10);
    // Parade start then end
    hold(4'b0100, 30);
    hold(4'b0000, 10);
    hold(4'b1000, 30);
    hold(4'b0000, 10);
    // Simultaneous buttons
    hold(4'b1100, 20);
    hold(4'b0000, 10);
    // Reset mid-debounce with raw_ta held high
    hold(4'b0001, 3);
    step(1'b1, 4'b0001);
    hold(4'b0001, 12);
    // Reset during a pending P pulse
    hold(4'b0100, 6);
    step(1'b1, 4'b0100);
    hold(4'b0100, 12);
    hold(4'b0000, 10);
    // Long stretch check on street A
    hold(4'b0001, 20);
    hold(4'b0000, 16);
    // Randomised segments with occasional resets
    for (int c = 0; c < 4; c++) hcnt[c] = 0;
    val = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (hcnt[c] == 0) begin
          val[c]  = 1'($urandom_range(0, 1));
          hcnt[c] = $urandom_range(1, 12);
        end else begin
          hcnt[c]--;
        end
      end
      step(($urandom_range(0, 249) == 0), val);
    end
    hold(4'b0000, 20);
    repeat (3) @(negedge clk);
    n_checks++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d required=0 pending expectations", expq.size());
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
